// File: rtl/fmul_stream_ctrl.sv
// Issues operand pairs to a fixed-latency FloPoCo multiplier and buffers its
// products in a credit-guarded first-word-fall-through FIFO.
module fmul_stream_ctrl #(
    parameter int WIDTH   = 11,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] mul_x,
    output logic [WIDTH-1:0] mul_y,
    input  logic [WIDTH-1:0] mul_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

    logic [LATENCY-1:0] vld_p;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [CNT_W:0]     credit_used;
    logic               issue;
    logic               push;
    logic               pop;

    // Every product issued but not yet popped holds a FIFO slot in reserve.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready    = reset && (credit_used < CAP);
    assign out_valid   = reset && (fifo_count != '0);
    assign out_data    = mem[rd_ptr];
    assign busy        = (reset && (inflight != '0)) || out_valid;

    assign issue = in_valid && in_ready;
    assign push  = vld_p[LATENCY-1];
    assign pop   = out_valid && out_ready;

    // Stage p0: operand registers feeding the multiplier.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_x <= '0;
            mul_y <= '0;
        end else if (issue) begin
            mul_x <= in_x;
            mul_y <= in_y;
        end
    end

    // Valid pipe mirrors the multiplier latency; its tail marks mul_r as live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Result FIFO: storage is data-only, pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= mul_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_stream_ctrl.sv
// Scoreboard bench for fmul_stream_ctrl with a behavioural FloPoCo multiplier
// model standing in for the downstream fmul.
module tb_fmul_stream_ctrl;
    localparam int W = 11;
    localparam int L = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [W-1:0] mul_x;
    logic [W-1:0] mul_y;
    logic [W-1:0] mul_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;

    typedef struct {
        logic [W-1:0] d;
        int           e;
    } ent_t;
    ent_t exp_q[$];
    logic [W-1:0] exp_mx;
    logic [W-1:0] exp_my;

    fmul_stream_ctrl #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .mul_x(mul_x), .mul_y(mul_y), .mul_r(mul_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference product: exception rules first, then truncating significand multiply.
    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [1:0] ea;
        logic [1:0] eb;
        logic       s;
        logic [9:0] sig;
        logic [3:0] frac;
        int         e;
        ea = a[10:9];
        eb = b[10:9];
        s  = a[8] ^ b[8];
        if (ea == 2'b11 || eb == 2'b11 || (ea == 2'b10 && eb == 2'b00) || (ea == 2'b00 && eb == 2'b10))
            return 11'b11000000000;
        if (ea == 2'b10 || eb == 2'b10) return {2'b10, s, 8'b0};
        if (ea == 2'b00 || eb == 2'b00) return {2'b00, s, 8'b0};
        sig = 10'({1'b1, a[3:0]}) * 10'({1'b1, b[3:0]});
        e   = int'(a[7:4]) + int'(b[7:4]) - 7;
        if (sig[9]) begin
            e++;
            frac = sig[8:5];
        end else begin
            frac = sig[7:4];
        end
        if (e > 15) return {2'b10, s, 8'b0};
        if (e < 0)  return {2'b00, s, 8'b0};
        return {2'b01, s, 4'(e), frac};
    endfunction

    // Downstream multiplier: L-1 register stages (one for L=2).
    always @(posedge clk) mul_r <= fmul(mul_x, mul_y);

    task automatic chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: expectations derived from the queue of issued-but-unpopped products.
    always @(negedge clk) begin
        if (!reset) begin
            chk(in_ready == 1'b0, "rst_in_ready", 11'(in_ready), 11'd0);
            chk(out_valid == 1'b0, "rst_out_valid", 11'(out_valid), 11'd0);
            chk(busy == 1'b0, "rst_busy", 11'(busy), 11'd0);
            exp_q.delete();
            exp_mx = '0;
            exp_my = '0;
        end else begin
            bit ev;
            ev = (exp_q.size() > 0) && (cyc >= exp_q[0].e + L);
            chk(mul_x == exp_mx, "mul_x", mul_x, exp_mx);
            chk(mul_y == exp_my, "mul_y", mul_y, exp_my);
            chk(in_ready == (exp_q.size() < D), "in_ready", 11'(in_ready), 11'(exp_q.size() < D));
            chk(busy == (exp_q.size() != 0), "busy", 11'(busy), 11'(exp_q.size() != 0));
            chk(out_valid == ev, "out_valid", 11'(out_valid), 11'(ev));
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_out", out_data, 11'd0);
                end else begin
                    ent_t h;
                    h = exp_q.pop_front();
                    chk(out_data == h.d, "out_data", out_data, h.d);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{d: fmul(in_x, in_y), e: cyc + 1});
                exp_mx = in_x;
                exp_my = in_y;
            end
        end
    end

    task automatic expect_head(input logic [W-1:0] v, input string nm, input int lat);
        int n;
        n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk(out_valid == 1'b1, {nm, "_valid"}, 11'(out_valid), 11'd1);
        chk(out_data == v, nm, out_data, v);
        if (lat > 0) chk(n == lat, {nm, "_latency"}, 11'(n), 11'(lat));
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(busy == 1'b0, "drain_busy", 11'(busy), 11'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nr;
        int p0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
        repeat (3) step();
        chk(mul_x == '0, "rst_mul_x", mul_x, 11'd0);
        chk(mul_y == '0, "rst_mul_y", mul_y, 11'd0);
        reset = 1'b1;
        @(negedge clk); #1;
        chk(in_ready == 1'b1, "ready_after_reset", 11'(in_ready), 11'd1);
        step();

        // Single issue 2.0 * 3.0 = 6.0, visible after edge k+L.
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 11'b01010000000; in_y = 11'b01010001000;
        step();
        in_valid = 1'b0;
        expect_head(11'b01010011000, "single_6p0", L + 1);
        drain();

        // Back-pressure: six offers with the consumer stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_x = 11'($urandom); in_y = 11'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk(acc == D, "bp_accepted", 11'(acc), 11'(D));
        chk(in_ready == 1'b0, "bp_ready_low", 11'(in_ready), 11'd0);
        step();
        drain();

        // Streaming: one issue per cycle with the consumer always ready.
        out_ready = 1'b1;
        acc = 0; nr = 0; p0 = pops;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_x = 11'($urandom); in_y = 11'($urandom);
            @(negedge clk);
            if (in_ready) acc++; else nr++;
            step();
        end
        in_valid = 1'b0;
        repeat (L) step();
        @(negedge clk); #1;
        chk(nr == 0, "stream_not_ready", 11'(nr), 11'd0);
        chk(acc == 16, "stream_accepted", 11'(acc), 11'd16);
        chk(pops - p0 == 16, "stream_pops", 11'(pops - p0), 11'd16);
        step();
        drain();

        // Simultaneous push and pop with DEPTH-1 products buffered.
        out_ready = 1'b0;
        for (int i = 0; i < D - 1; i++) begin
            in_valid = 1'b1; in_x = 11'($urandom); in_y = 11'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (L) step();
        in_valid = 1'b1; in_x = 11'($urandom); in_y = 11'($urandom);
        step();
        in_valid = 1'b0;
        repeat (L - 1) step();
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk(in_ready == 1'b0, "pp_ready_before", 11'(in_ready), 11'd0);
        step();
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk(in_ready == 1'b1, "pp_ready_after", 11'(in_ready), 11'd1);
        chk(out_valid == 1'b1, "pp_valid_after", 11'(out_valid), 11'd1);
        step();
        drain();

        // Exception products pass through untouched.
        in_valid = 1'b1; in_x = 11'b11000000000; in_y = 11'b01010000000;
        step();
        in_valid = 1'b0;
        expect_head(11'b11000000000, "nan_pass", 0);
        in_valid = 1'b1; in_x = 11'b00000000000; in_y = 11'b01010001000;
        step();
        in_valid = 1'b0;
        expect_head(11'b00000000000, "zero_pass", 0);
        drain();

        // Reset one cycle after an issue discards the pair.
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 11'b01010000000; in_y = 11'b01010001000;
        step();
        in_valid = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        nr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) nr++;
        end
        chk(nr == 0, "midreset_quiet", 11'(nr), 11'd0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_x = 11'($urandom);
            in_y = 11'($urandom);
            step();
        end
        drain();
        @(negedge clk); #1;
        chk(exp_q.size() == 0, "all_delivered", 11'(exp_q.size()), 11'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
